time_of_day: RTL and testbench

//  24-hour BCD time-of-day counter. It is the upstream stage of the reminder logic and drives its hMSD/hLSD hour digits.
//  An internal prescaler divides clk down to a 1 s tick, which advances cascaded seconds/minutes/hours BCD counters.
//  Two edge-detected user inputs set the hours and minutes.

---
 rtl/time_of_day.sv | 117 +++++++++++
 tb/tb_time_of_day.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/time_of_day.sv
// 24-hour BCD time-of-day counter driven by a clk prescaler, with edge-detected
// hour/minute set buttons and a registered one-cycle strobe per second.
module time_of_day #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       incHour,
  input  logic       incMin,
  output logic [3:0] hMSD,
  output logic [3:0] hLSD,
  output logic [3:0] mMSD,
  output logic [3:0] mLSD,
  output logic [3:0] sMSD,
  output logic [3:0] sLSD,
  output logic       secTick
);

  localparam int W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] PRESC_MAX = W'(TICK_DIV - 1);

  logic [W-1:0] presc_q, presc_d;
  logic         inc_hour_q, inc_min_q;
  logic [3:0]   h_msd_q, h_lsd_q, m_msd_q, m_lsd_q, s_msd_q, s_lsd_q;
  logic [3:0]   h_msd_d, h_lsd_d, m_msd_d, m_lsd_d, s_msd_d, s_lsd_d;
  logic         sec_tick_q, sec_tick_d;
  logic         hour_edge, min_edge, tick;

  // Returns {msd, lsd} advanced by one within 00..59.
  function automatic logic [7:0] inc60(input logic [3:0] msd, input logic [3:0] lsd);
    if (lsd != 4'd9)      return {msd, lsd + 4'd1};
    else if (msd != 4'd5) return {msd + 4'd1, 4'd0};
    else                  return 8'h00;
  endfunction

  function automatic logic is59(input logic [3:0] msd, input logic [3:0] lsd);
    return (msd == 4'd5) && (lsd == 4'd9);
  endfunction

  // Returns {msd, lsd} advanced by one within 00..23.
  function automatic logic [7:0] inc24(input logic [3:0] msd, input logic [3:0] lsd);
    if (msd == 4'd2 && lsd == 4'd3) return 8'h00;
    else if (lsd == 4'd9)           return {msd + 4'd1, 4'd0};
    else                            return {msd, lsd + 4'd1};
  endfunction

  always_comb begin
    hour_edge  = incHour & ~inc_hour_q;
    min_edge   = incMin & ~inc_min_q;
    tick       = enable && (presc_q == PRESC_MAX);

    presc_d    = presc_q;
    sec_tick_d = 1'b0;
    h_msd_d    = h_msd_q;
    h_lsd_d    = h_lsd_q;
    m_msd_d    = m_msd_q;
    m_lsd_d    = m_lsd_q;
    s_msd_d    = s_msd_q;
    s_lsd_d    = s_lsd_q;

    if (min_edge)    presc_d = '0;
    else if (enable) presc_d = tick ? '0 : presc_q + W'(1);

    // Set edges take priority over the tick and never carry between fields.
    if (hour_edge || min_edge) begin
      if (hour_edge) {h_msd_d, h_lsd_d} = inc24(h_msd_q, h_lsd_q);
      if (min_edge) begin
        {m_msd_d, m_lsd_d} = inc60(m_msd_q, m_lsd_q);
        s_msd_d = 4'd0;
        s_lsd_d = 4'd0;
      end
    end else if (tick) begin
      sec_tick_d = 1'b1;
      {s_msd_d, s_lsd_d} = inc60(s_msd_q, s_lsd_q);
      if (is59(s_msd_q, s_lsd_q)) begin
        {m_msd_d, m_lsd_d} = inc60(m_msd_q, m_lsd_q);
        if (is59(m_msd_q, m_lsd_q)) {h_msd_d, h_lsd_d} = inc24(h_msd_q, h_lsd_q);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q    <= '0;
      inc_hour_q <= 1'b0;
      inc_min_q  <= 1'b0;
      h_msd_q    <= 4'd0;
      h_lsd_q    <= 4'd0;
      m_msd_q    <= 4'd0;
      m_lsd_q    <= 4'd0;
      s_msd_q    <= 4'd0;
      s_lsd_q    <= 4'd0;
      sec_tick_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      inc_hour_q <= incHour;
      inc_min_q  <= incMin;
      h_msd_q    <= h_msd_d;
      h_lsd_q    <= h_lsd_d;
      m_msd_q    <= m_msd_d;
      m_lsd_q    <= m_lsd_d;
      s_msd_q    <= s_msd_d;
      s_lsd_q    <= s_lsd_d;
      sec_tick_q <= sec_tick_d;
    end
  end

  assign hMSD    = h_msd_q;
  assign hLSD    = h_lsd_q;
  assign mMSD    = m_msd_q;
  assign mLSD    = m_lsd_q;
  assign sMSD    = s_msd_q;
  assign sLSD    = s_lsd_q;
  assign secTick = sec_tick_q;

endmodule

// File: tb/tb_time_of_day.sv
// Bench for time_of_day: seconds-of-day reference model checked every cycle,
// directed scenarios pinned with literal times, then randomized stimulus.
module tb_time_of_day;
  localparam int DIV = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic incHour = 1'b0;
  logic incMin = 1'b0;
  logic [3:0] hMSD, hLSD, mMSD, mLSD, sMSD, sLSD;
  logic secTick;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  // Reference model: time as seconds since midnight.
  int  m_tod = 0;
  int  m_presc = 0;
  bit  m_tick = 0;
  bit  m_ph = 0, m_pm = 0;
  bit  prev_tick = 0;

  time_of_day #(.TICK_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .enable(enable), .incHour(incHour), .incMin(incMin),
    .hMSD(hMSD), .hLSD(hLSD), .mMSD(mMSD), .mLSD(mLSD), .sMSD(sMSD), .sLSD(sLSD),
    .secTick(secTick)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_tod = 0; m_presc = 0; m_tick = 0; m_ph = 0; m_pm = 0;
    end else begin
      bit he, me, wrap;
      int h, m, s;
      he = incHour && !m_ph;
      me = incMin && !m_pm;
      m_ph = incHour;
      m_pm = incMin;
      wrap = enable && (m_presc == DIV - 1);
      h = m_tod / 3600;
      m = (m_tod / 60) % 60;
      s = m_tod % 60;
      if (me)          m_presc = 0;
      else if (enable) m_presc = wrap ? 0 : m_presc + 1;
      if (he || me) begin
        if (he) h = (h + 1) % 24;
        if (me) begin m = (m + 1) % 60; s = 0; end
        m_tod = h * 3600 + m * 60 + s;
        m_tick = 0;
      end else if (wrap) begin
        m_tod = (m_tod + 1) % 86400;
        m_tick = 1;
      end else begin
        m_tick = 0;
      end
    end
  end

  function automatic logic [24:0] pack(int tod, bit tk);
    int h, m, s;
    h = tod / 3600; m = (tod / 60) % 60; s = tod % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), tk};
  endfunction

  function automatic logic [24:0] dut_vec();
    return {hMSD, hLSD, mMSD, mLSD, sMSD, sLSD, secTick};
  endfunction

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      logic [24:0] exp_v, act_v;
      bit inv_ok;
      exp_v = pack(m_tod, m_tick);
      act_v = dut_vec();
      total++;
      if (act_v !== exp_v) begin
        bad++;
        $display("FAIL model_cmp t=%0t got=%h want=%h", $time, act_v, exp_v);
      end
      inv_ok = (hMSD <= 2) && (hLSD <= 9) && !(hMSD == 2 && hLSD > 3) && (mMSD <= 5) &&
               (mLSD <= 9) && (sMSD <= 5) && (sLSD <= 9) && !(prev_tick && secTick);
      total++;
      if (!inv_ok) begin
        bad++;
        $display("FAIL invariant t=%0t got=%h prev_tick=%0b want=legal", $time, act_v, prev_tick);
      end
      prev_tick = secTick;
    end else begin
      prev_tick = 0;
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Literal pin: checks both the DUT and the model against a hand-computed time.
  task automatic lit(string name, int hh, int mm, int ss, bit tk);
    logic [24:0] want;
    want = pack(hh * 3600 + mm * 60 + ss, tk);
    total++;
    if (dut_vec() !== want) begin
      bad++;
      $display("FAIL %s dut got=%h want=%h", name, dut_vec(), want);
    end
    total++;
    if (pack(m_tod, m_tick) !== want) begin
      bad++;
      $display("FAIL %s model got=%h want=%h", name, pack(m_tod, m_tick), want);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; incHour = 1'b0; incMin = 1'b0;
    step(1);
    reset = 1'b0;
  endtask

  task automatic press_h(int n);
    repeat (n) begin incHour = 1'b1; step(1); incHour = 1'b0; step(1); end
  endtask

  task automatic press_m(int n);
    repeat (n) begin incMin = 1'b1; step(1); incMin = 1'b0; step(1); end
  endtask

  initial begin
    step(2);
    chk_en = 1'b1;

    // 1: run from reset
    enable = 1'b1;
    do_reset();
    lit("reset_state", 0, 0, 0, 0);
    step(3);
    lit("before_first_tick", 0, 0, 0, 0);
    step(1);
    lit("first_tick", 0, 0, 1, 1);
    step(1);
    lit("tick_one_cycle", 0, 0, 1, 0);
    step(235);
    lit("one_minute", 0, 1, 0, 1);

    // 2: midnight rollover
    enable = 1'b0;
    do_reset();
    press_h(23);
    press_m(59);
    lit("set_2359", 23, 59, 0, 0);
    enable = 1'b1;
    step(200);
    lit("at_235950", 23, 59, 50, 1);
    step(40);
    lit("midnight_wrap", 0, 0, 0, 1);

    // 3: held button acts once
    enable = 1'b0;
    incHour = 1'b1;
    step(10);
    lit("hold_once", 1, 0, 0, 0);
    incHour = 1'b0;
    step(2);
    press_h(1);
    lit("repress", 2, 0, 0, 0);

    // 4: incMin edge in the tick cycle
    do_reset();
    press_h(12);
    press_m(34);
    enable = 1'b1;
    step(224);
    lit("at_123456", 12, 34, 56, 1);
    step(3);
    incMin = 1'b1;
    step(1);
    incMin = 1'b0;
    lit("min_suppress_tick", 12, 35, 0, 0);
    step(3);
    lit("presc_cleared", 12, 35, 0, 0);
    step(1);
    lit("tick_after_clear", 12, 35, 1, 1);

    // 5: freeze with enable=0
    enable = 1'b0;
    do_reset();
    press_h(8);
    enable = 1'b1;
    step(12);
    lit("at_080003", 8, 0, 3, 1);
    step(2);
    enable = 1'b0;
    step(20);
    lit("frozen", 8, 0, 3, 0);
    press_h(1);
    lit("set_while_frozen", 9, 0, 3, 0);
    enable = 1'b1;
    step(1);
    lit("resume_no_tick", 9, 0, 3, 0);
    step(1);
    lit("resume_tick", 9, 0, 4, 1);

    // 6: asynchronous reset mid-cycle
    enable = 1'b0;
    do_reset();
    press_h(17);
    press_m(42);
    enable = 1'b1;
    step(36);
    lit("at_174209", 17, 42, 9, 1);
    step(1);
    #2 reset = 1'b1;
    #1 lit("async_reset", 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    step(3);
    lit("restart_no_tick", 0, 0, 0, 0);
    step(1);
    lit("restart_tick", 0, 0, 1, 1);

    // Randomized stimulus
    for (int i = 0; i < 4000; i++) begin
      enable  = ($urandom_range(0, 9) != 0);
      incHour = ($urandom_range(0, 5) == 0) ? ~incHour : incHour;
      incMin  = ($urandom_range(0, 5) == 0) ? ~incMin : incMin;
      if ($urandom_range(0, 499) == 0) begin
        #2 reset = 1'b1;
        #2 reset = 1'b0;
      end
      step(1);
    end

    // Long enabled run to cross hour boundaries from a random setting
    incHour = 1'b0; incMin = 1'b0;
    enable = 1'b0;
    step(1);
    press_h(int'($urandom_range(0, 23)));
    press_m(int'($urandom_range(50, 59)));
    enable = 1'b1;
    step(3000);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
